// File: rtl/baud_tick_sched_pkg.sv
// Shared types and defaults for the baud tick scheduler.
// BAUD_FRAC_EN adds the fractional-divisor default width.
package baud_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam int unsigned DIV_MIN   = 2;
  localparam int unsigned DIV_W_DEF = 16;
  localparam int unsigned OSR_DEF   = 16;
`ifdef BAUD_FRAC_EN
  localparam int unsigned FRAC_W_DEF = 4;
`endif

endpackage

// File: rtl/baud_tick_sched_if.sv
// Divisor configuration handshake for baud_tick_sched.
// BAUD_FRAC_EN adds the cfg_frac field.
interface baud_tick_sched_if
  import baud_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
`ifdef BAUD_FRAC_EN
  , parameter int unsigned FRAC_W = FRAC_W_DEF
`endif
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [DIV_W-1:0] cfg_div;
`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] cfg_frac;

  modport master (output cfg_valid, output cfg_div, output cfg_frac, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_div, input cfg_frac, output cfg_ready);
`else
  modport master (output cfg_valid, output cfg_div, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_div, output cfg_ready);
`endif

endinterface

// File: rtl/baud_tick_sched_tick_counter.sv
// Modulo counter: counts 0..limit while inc is high, wrap flags the limit cycle.
module tick_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_in,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         wrap
);

  assign wrap = inc && (count == limit);

  always_ff @(posedge clk_in) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/baud_tick_sched.sv
// Oversample/bit tick scheduler with bit-boundary divisor switching.
// BAUD_FRAC_EN enables the fractional divisor accumulator.
module baud_tick_sched
  import baud_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF,
  parameter int unsigned OSR   = OSR_DEF
`ifdef BAUD_FRAC_EN
  , parameter int unsigned FRAC_W = FRAC_W_DEF
`endif
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 en,
  baud_tick_sched_if.slave     cfg,
  output logic                 os_tick,
  output logic                 bit_tick,
  output logic                 active,
  output logic                 cfg_err
);

  localparam int unsigned SUB_W = $clog2(OSR);

  state_t           state;
  logic [DIV_W-1:0] div_q, pend_div, div_in, os_cnt, os_limit;
  logic [SUB_W-1:0] sub_cnt;
  logic             configured, xfer, running, os_wrap, bit_edge, switch_now, cnt_clear;

  assign cfg.cfg_ready = (state != PEND);
  assign active        = (state != IDLE);
  assign xfer          = cfg.cfg_valid && cfg.cfg_ready;
  assign div_in        = (cfg.cfg_div < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : cfg.cfg_div;
  assign running       = en && (state != IDLE);
  // The switch shares the edge that registers bit_tick, so the first new
  // period starts exactly on the bit boundary.
  assign switch_now    = running && (state == PEND) && bit_edge;
  assign cnt_clear     = !running || switch_now;

`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] frac_q, pend_frac, acc;
  logic              stretch;

  assign os_limit = stretch ? div_q : div_q - DIV_W'(1);

  always_ff @(posedge clk_in) begin
    if (reset || cnt_clear) begin
      acc     <= '0;
      stretch <= 1'b0;
    end else if (os_wrap) begin
      {stretch, acc} <= {1'b0, acc} + {1'b0, frac_q};
    end
  end
`else
  assign os_limit = div_q - DIV_W'(1);
`endif

  tick_counter #(.W(DIV_W)) u_os_cnt (
    .clk_in (clk_in),
    .reset  (reset),
    .clear  (cnt_clear),
    .inc    (running),
    .limit  (os_limit),
    .count  (os_cnt),
    .wrap   (os_wrap)
  );

  tick_counter #(.W(SUB_W)) u_sub_cnt (
    .clk_in (clk_in),
    .reset  (reset),
    .clear  (cnt_clear),
    .inc    (os_wrap),
    .limit  (SUB_W'(OSR - 1)),
    .count  (sub_cnt),
    .wrap   (bit_edge)
  );

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state      <= IDLE;
      div_q      <= DIV_W'(DIV_MIN);
      pend_div   <= DIV_W'(DIV_MIN);
      configured <= 1'b0;
      os_tick    <= 1'b0;
      bit_tick   <= 1'b0;
      cfg_err    <= 1'b0;
`ifdef BAUD_FRAC_EN
      frac_q     <= '0;
      pend_frac  <= '0;
`endif
    end else begin
      os_tick  <= running && os_wrap;
      bit_tick <= running && bit_edge;
      cfg_err  <= xfer && (cfg.cfg_div < DIV_W'(DIV_MIN));
      unique case (state)
        IDLE: begin
          if (xfer) begin
            div_q      <= div_in;
            configured <= 1'b1;
`ifdef BAUD_FRAC_EN
            frac_q     <= cfg.cfg_frac;
`endif
          end
          if (en && configured) state <= RUN;
        end
        RUN: begin
          if (!en) begin
            state <= IDLE;
            if (xfer) begin
              div_q <= div_in;
`ifdef BAUD_FRAC_EN
              frac_q <= cfg.cfg_frac;
`endif
            end
          end else if (xfer) begin
            pend_div <= div_in;
`ifdef BAUD_FRAC_EN
            pend_frac <= cfg.cfg_frac;
`endif
            state <= PEND;
          end
        end
        PEND: begin
          if (!en || switch_now) begin
            div_q <= pend_div;
`ifdef BAUD_FRAC_EN
            frac_q <= pend_frac;
`endif
            state <= en ? RUN : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_os_cnt;
  assign unused_os_cnt = ^{os_cnt, sub_cnt};

endmodule

// File: tb/tb_baud_tick_sched.sv
// Directed bench for baud_tick_sched (OSR=4); fractional test only with BAUD_FRAC_EN.
module tb_baud_tick_sched;
  import baud_pkg::*;

  localparam int unsigned DIV_W = 16;
  localparam int unsigned OSR   = 4;

  logic clk_in = 1'b0;
  logic reset, en;
  logic os_tick, bit_tick, active, cfg_err;
  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk_in = ~clk_in;

`ifdef BAUD_FRAC_EN
  logic [3:0] frac_set = 4'd0;
  baud_tick_sched_if #(.DIV_W(DIV_W), .FRAC_W(4)) cfg ();
  baud_tick_sched #(.DIV_W(DIV_W), .OSR(OSR), .FRAC_W(4)) dut (
`else
  baud_tick_sched_if #(.DIV_W(DIV_W)) cfg ();
  baud_tick_sched #(.DIV_W(DIV_W), .OSR(OSR)) dut (
`endif
    .clk_in   (clk_in),
    .reset    (reset),
    .en       (en),
    .cfg      (cfg),
    .os_tick  (os_tick),
    .bit_tick (bit_tick),
    .active   (active),
    .cfg_err  (cfg_err)
  );

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Reset, load divisor d while idle, enable; returns one sample after RUN entry (t=0).
  task automatic setup(input logic [DIV_W-1:0] d);
    reset = 1'b1; en = 1'b0; cfg.cfg_valid = 1'b0;
    step(); step();
    reset = 1'b0;
    cfg.cfg_valid = 1'b1; cfg.cfg_div = d;
`ifdef BAUD_FRAC_EN
    cfg.cfg_frac = frac_set;
`endif
    step();
    cfg.cfg_valid = 1'b0; en = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; cfg.cfg_valid = 1'b0; cfg.cfg_div = '0;
`ifdef BAUD_FRAC_EN
    cfg.cfg_frac = '0;
`endif
    step(); step();
    reset = 1'b0;
    total++; if (os_tick !== 1'b0)       begin bad++; $display("FAIL reset_os got=%b want=0", os_tick); end
    total++; if (bit_tick !== 1'b0)      begin bad++; $display("FAIL reset_bit got=%b want=0", bit_tick); end
    total++; if (active !== 1'b0)        begin bad++; $display("FAIL reset_active got=%b want=0", active); end
    total++; if (cfg_err !== 1'b0)       begin bad++; $display("FAIL reset_err got=%b want=0", cfg_err); end
    total++; if (cfg.cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", cfg.cfg_ready); end
    en = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      step();
      total++; if (active !== 1'b0 || os_tick !== 1'b0) begin
        bad++; $display("FAIL unconfigured_run t=%0d active=%b os=%b want 0/0", t, active, os_tick);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_basic();
    logic eo, eb;
    setup(5);
    total++; if (active !== 1'b1) begin bad++; $display("FAIL basic_active got=%b want=1", active); end
    for (int t = 1; t <= 45; t++) begin
      step();
      eo = (t % 5 == 0); eb = (t % 20 == 0);
      total++; if (os_tick !== eo)  begin bad++; $display("FAIL basic_os t=%0d got=%b want=%b", t, os_tick, eo); end
      total++; if (bit_tick !== eb) begin bad++; $display("FAIL basic_bit t=%0d got=%b want=%b", t, bit_tick, eb); end
      total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL basic_err t=%0d got=%b want=0", t, cfg_err); end
    end
  endtask

  task automatic test_switch();
    logic eo, eb, er;
    setup(5);
    for (int t = 1; t <= 34; t++) begin
      step();
      eo = (t <= 20) ? (t % 5 == 0) : ((t - 20) % 3 == 0);
      eb = (t == 20) || (t == 32);
      er = !(t >= 8 && t < 20);
      total++; if (os_tick !== eo)       begin bad++; $display("FAIL switch_os t=%0d got=%b want=%b", t, os_tick, eo); end
      total++; if (bit_tick !== eb)      begin bad++; $display("FAIL switch_bit t=%0d got=%b want=%b", t, bit_tick, eb); end
      total++; if (cfg.cfg_ready !== er) begin bad++; $display("FAIL switch_ready t=%0d got=%b want=%b", t, cfg.cfg_ready, er); end
      if (t == 7) begin cfg.cfg_valid = 1'b1; cfg.cfg_div = 3; end
      if (t == 8) cfg.cfg_valid = 1'b0;
    end
  endtask

  task automatic test_clamp();
    logic eo, eb;
    reset = 1'b1; en = 1'b0; cfg.cfg_valid = 1'b0;
    step();
    reset = 1'b0; cfg.cfg_valid = 1'b1; cfg.cfg_div = 1;
    step();
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL clamp_err_div1 got=%b want=1", cfg_err); end
    cfg.cfg_div = 0;
    step();
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL clamp_err_div0 got=%b want=1", cfg_err); end
    cfg.cfg_valid = 1'b0;
    step();
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL clamp_err_clear got=%b want=0", cfg_err); end
    en = 1'b1;
    step();
    for (int t = 1; t <= 10; t++) begin
      step();
      eo = (t % 2 == 0); eb = (t % 8 == 0);
      total++; if (os_tick !== eo)  begin bad++; $display("FAIL clamp_os t=%0d got=%b want=%b", t, os_tick, eo); end
      total++; if (bit_tick !== eb) begin bad++; $display("FAIL clamp_bit t=%0d got=%b want=%b", t, bit_tick, eb); end
    end
  endtask

  task automatic test_en_drop();
    logic eo, eb, ea;
    setup(5);
    for (int t = 1; t <= 34; t++) begin
      step();
      if (t <= 12)      eo = (t % 5 == 0);
      else if (t <= 19) eo = 1'b0;
      else              eo = ((t - 19) % 3 == 0);
      eb = (t == 31);
      ea = (t <= 12) || (t >= 19);
      total++; if (os_tick !== eo)  begin bad++; $display("FAIL endrop_os t=%0d got=%b want=%b", t, os_tick, eo); end
      total++; if (bit_tick !== eb) begin bad++; $display("FAIL endrop_bit t=%0d got=%b want=%b", t, bit_tick, eb); end
      total++; if (active !== ea)   begin bad++; $display("FAIL endrop_active t=%0d got=%b want=%b", t, active, ea); end
      if (t == 7)  begin cfg.cfg_valid = 1'b1; cfg.cfg_div = 3; end
      if (t == 8)  cfg.cfg_valid = 1'b0;
      if (t == 12) en = 1'b0;
      if (t == 18) en = 1'b1;
    end
  endtask

  task automatic test_reset_pend();
    logic eo, ea, er;
    setup(5);
    for (int t = 1; t <= 36; t++) begin
      step();
      if (t <= 14)      eo = (t % 5 == 0);
      else if (t <= 24) eo = 1'b0;
      else              eo = ((t - 24) % 4 == 0);
      ea = (t <= 14) || (t >= 24);
      er = !(t >= 8 && t <= 14);
      total++; if (os_tick !== eo)       begin bad++; $display("FAIL rstpend_os t=%0d got=%b want=%b", t, os_tick, eo); end
      total++; if (active !== ea)        begin bad++; $display("FAIL rstpend_active t=%0d got=%b want=%b", t, active, ea); end
      total++; if (cfg.cfg_ready !== er) begin bad++; $display("FAIL rstpend_ready t=%0d got=%b want=%b", t, cfg.cfg_ready, er); end
      if (t >= 15 && t <= 23) begin
        total++; if (bit_tick !== 1'b0 || cfg_err !== 1'b0) begin
          bad++; $display("FAIL rstpend_quiet t=%0d bit=%b err=%b want 0/0", t, bit_tick, cfg_err);
        end
      end
      if (t == 7)  begin cfg.cfg_valid = 1'b1; cfg.cfg_div = 3; end
      if (t == 8)  cfg.cfg_valid = 1'b0;
      if (t == 14) reset = 1'b1;
      if (t == 16) reset = 1'b0;
      if (t == 22) begin cfg.cfg_valid = 1'b1; cfg.cfg_div = 4; end
      if (t == 23) cfg.cfg_valid = 1'b0;
    end
  endtask

`ifdef BAUD_FRAC_EN
  task automatic test_frac();
    int unsigned ticks[$];
    int unsigned span, iv;
    frac_set = 4'd8;
    setup(4);
    frac_set = 4'd0;
    for (int unsigned t = 1; t <= 200 && ticks.size() < 33; t++) begin
      step();
      if (os_tick === 1'b1) ticks.push_back(t);
    end
    total++;
    if (ticks.size() < 33) begin
      bad++; $display("FAIL frac_timeout ticks=%0d want=33", ticks.size());
    end else begin
      span = ticks[32] - ticks[0];
      if (span !== 144) begin bad++; $display("FAIL frac_span got=%0d want=144", span); end
      for (int k = 1; k <= 32; k++) begin
        iv = ticks[k] - ticks[k-1];
        total++; if (iv !== ((k % 2 == 1) ? 4 : 5)) begin
          bad++; $display("FAIL frac_interval k=%0d got=%0d want=%0d", k, iv, (k % 2 == 1) ? 4 : 5);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_switch();
    test_clamp();
    test_en_drop();
    test_reset_pend();
`ifdef BAUD_FRAC_EN
    test_frac();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
